// File: rtl/tns18_codec_if.sv
// tns18_codec_if: bus signals between the TSV codec and its user.
//   datain  [16:0] value to transmit (0..117648)
//   tsv     [17:0] registered encoded TSV word
//   tsv_rx  [17:0] received TSV word into the decoder
//   dataout [16:0] decoded value, combinational from tsv_rx
// master: the side that supplies data and the received word.
// slave : the codec.
interface tns18_codec_if;
    logic [16:0] datain;
    logic [17:0] tsv;
    logic [17:0] tsv_rx;
    logic [16:0] dataout;

    modport master (output datain, output tsv_rx, input tsv, input dataout);
    modport slave  (input datain, input tsv_rx, output tsv, output dataout);
endinterface

// File: rtl/tns18_codec.sv
// tns18_codec: transition-constrained codec for an 18-TSV link.
// The 17-bit value is split into six radix-7 digits, and each digit is
// mapped onto one 3-wire group. Digit 6 has two codewords, and the choice
// depends on the group's currently driven g2. This guarantees that
// (g0,g1,g2)=(0,0,1) never follows g2=0 and (1,1,0) never follows g2=1.
// Ports:
//   clock   rising-edge clock for the encoder output register
//   rst_n   asynchronous active-low reset (clears tsv)
//   bus     tns18_codec_if.slave: datain, tsv, tsv_rx, dataout

// Per-group codeword logic. Bit order is {g2,g1,g0}, matching tsv[3j+2:3j].
module tns18_grp (
    input  logic [2:0] digit,
    input  logic       prev_g2,
    output logic [2:0] cw,
    input  logic [2:0] rx,
    output logic [2:0] rdig
);
    always_comb begin
        cw = 3'b000;
        unique case (digit)
            3'd0:    cw = 3'b000;
            3'd1:    cw = 3'b010;
            3'd2:    cw = 3'b110;
            3'd3:    cw = 3'b001;
            3'd4:    cw = 3'b101;
            3'd5:    cw = 3'b111;
            // digit 6: choose the codeword that keeps the wire constraint
            default: cw = prev_g2 ? 3'b100 : 3'b011;
        endcase
    end

    always_comb begin
        rdig = 3'd6;
        unique case (rx)
            3'b000:  rdig = 3'd0;
            3'b010:  rdig = 3'd1;
            3'b110:  rdig = 3'd2;
            3'b001:  rdig = 3'd3;
            3'b101:  rdig = 3'd4;
            3'b111:  rdig = 3'd5;
            default: rdig = 3'd6;   // 3'b011 and 3'b100 are both digit 6
        endcase
    end
endmodule

module tns18_codec (
    input  logic          clock,
    input  logic          rst_n,
    tns18_codec_if.slave  bus
);
    localparam int DATA_W    = 17;
    localparam int TSV_W     = 18;
    localparam int GROUPS    = 6;
    localparam int RADIX     = 7;
    localparam int VALID_MAX = 117648;

    logic [GROUPS:0][DATA_W-1:0] quo;
    logic [GROUPS-1:0][2:0]      dig;
    logic [GROUPS-1:0][2:0]      cw;
    logic [GROUPS-1:0][2:0]      rdig;
    logic [TSV_W-1:0]            tsv_q;
    logic [DATA_W-1:0]           acc;
    logic                        in_range;

    // Digit extraction: a div/mod-by-constant chain from the least
    // significant digit upward.
    always_comb begin
        quo    = '0;
        dig    = '0;
        quo[0] = bus.datain;
        for (int j = 0; j < GROUPS; j++) begin
            dig[j]   = 3'(quo[j] % DATA_W'(RADIX));
            quo[j+1] = quo[j] / DATA_W'(RADIX);
        end
    end

    genvar g;
    generate
        for (g = 0; g < GROUPS; g++) begin : g_grp
            tns18_grp u_grp (
                .digit   (dig[g]),
                .prev_g2 (tsv_q[3*g+2]),
                .cw      (cw[g]),
                .rx      (bus.tsv_rx[3*g +: 3]),
                .rdig    (rdig[g])
            );
        end
    endgenerate

    assign in_range = (bus.datain <= DATA_W'(VALID_MAX));

    // The registered g2 bits are the only codec state. Out-of-range
    // input holds the line, so that state also stays unchanged.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)        tsv_q <= '0;
        else if (in_range) tsv_q <= cw;
    end

    assign bus.tsv = tsv_q;

    // Decoder uses Horner evaluation from the most significant group. The
    // result is at most 7^6-1, so no intermediate value overflows 17 bits.
    always_comb begin
        acc = '0;
        for (int j = GROUPS - 1; j >= 0; j--) begin
            acc = acc * DATA_W'(RADIX) + DATA_W'(rdig[j]);
        end
    end

    assign bus.dataout = acc;
endmodule

// File: tb/tb_tns18_codec.sv
// tb_tns18_codec: scoreboard bench for tns18_codec in loopback.
// The driver applies datain on the falling edge and pushes the model's
// expected tsv/dataout. The monitor pops one entry and compares after
// every rising edge. It also checks the per-group wire constraint and the
// reset values.
`timescale 1ns/1ps
module tb_tns18_codec;
    localparam int VMAX = 117648;

    typedef struct {
        logic [17:0] tsv;
        logic [16:0] dout;
        int          din;
    } exp_t;

    logic clock;
    logic rst_n;
    tns18_codec_if bus();

    assign bus.tsv_rx = bus.tsv;

    tns18_codec dut (.clock(clock), .rst_n(rst_n), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t        exp_q[$];
    int          compared;
    int          mismatched;
    logic [17:0] m_tsv;
    logic [16:0] m_dout;

    // Codeword for a digit, given the group's g2 currently on the line.
    // Returned as {g2,g1,g0}.
    function automatic logic [2:0] cw_of(input int d, input logic pg2);
        case (d)
            0: return 3'b000;   // (0,0,0)
            1: return 3'b010;   // (0,1,0)
            2: return 3'b110;   // (0,1,1)
            3: return 3'b001;   // (1,0,0)
            4: return 3'b101;   // (1,0,1)
            5: return 3'b111;   // (1,1,1)
            default: return pg2 ? 3'b100 : 3'b011;
        endcase
    endfunction

    task automatic model_reset();
        m_tsv  = '0;
        m_dout = '0;
    endtask

    task automatic drive(input int v);
        exp_t e;
        int   r;
        @(negedge clock);
        bus.datain = 17'(v);
        if (v <= VMAX) begin
            r = v;
            for (int j = 0; j < 6; j++) begin
                m_tsv[3*j +: 3] = cw_of(r % 7, m_tsv[3*j+2]);
                r = r / 7;
            end
            m_dout = 17'(v);
        end
        e.tsv  = m_tsv;
        e.dout = m_dout;
        e.din  = v;
        exp_q.push_back(e);
    endtask

    // Asserts reset away from the clock edge, with the scoreboard drained.
    // The reset is held across two rising edges.
    task automatic do_reset();
        @(posedge clock);
        #3 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [17:0] prev;
        logic [2:0]  grp;
        int          viol;
        prev = '0;
        forever begin
            @(posedge clock or negedge rst_n);
            #1;
            if (!rst_n) begin
                prev = '0;
                compared++;
                if (bus.tsv !== 18'd0) begin
                    mismatched++;
                    $display("FAIL rst_tsv act=%0d req=0", bus.tsv);
                end
                compared++;
                if (bus.dataout !== 17'd0) begin
                    mismatched++;
                    $display("FAIL rst_dout act=%0d req=0", bus.dataout);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compared++;
                if (bus.tsv !== e.tsv) begin
                    mismatched++;
                    $display("FAIL tsv din=%0d act=%0d req=%0d", e.din, bus.tsv, e.tsv);
                end
                compared++;
                if (bus.dataout !== e.dout) begin
                    mismatched++;
                    $display("FAIL dout din=%0d act=%0d req=%0d", e.din, bus.dataout, e.dout);
                end
                viol = 0;
                for (int j = 0; j < 6; j++) begin
                    grp = bus.tsv[3*j +: 3];
                    if ((grp == 3'b100 && !prev[3*j+2]) || (grp == 3'b011 && prev[3*j+2]))
                        viol++;
                end
                compared++;
                if (viol != 0) begin
                    mismatched++;
                    $display("FAIL line din=%0d act=%0d violations req=0 prev=%0d tsv=%0d",
                             e.din, viol, prev, bus.tsv);
                end
                prev = bus.tsv;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.datain = '0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;

        // digit-6 codeword selection in group 0
        drive(6); drive(6); drive(4); drive(6);
        drive(49);
        // all groups carry digit 6 from the reset state
        do_reset();
        drive(VMAX);
        drive(VMAX);
        // out-of-range values hold the line
        do_reset();
        drive(49);
        drive(VMAX + 1);
        drive(131071);
        drive(6);
        // a reset in the middle of the stream, then random loopback
        do_reset();
        for (int i = 0; i < 40000; i++) drive($urandom_range(VMAX, 0));
        // mixed in-range and out-of-range traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(9, 0) == 0) drive($urandom_range(131071, VMAX + 1));
            else                           drive($urandom_range(VMAX, 0));
        end
        do_reset();
        drive(6);

        @(posedge clock);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
